// File: rtl/kaliski_pkg.sv
// Shared defaults, FSM state encoding and result record for the Kaliski phase-1 engine.
package kaliski_pkg;

    localparam int unsigned W_DEF  = 256;
    localparam int unsigned KW_DEF = 10;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        REDUCE,
        DONE
    } state_e;

    typedef struct packed {
        logic [W_DEF-1:0]  x;
        logic [KW_DEF-1:0] k;
        logic              err;
    } result_t;

endpackage

// File: rtl/kaliski_step_datapath.sv
// One Kaliski phase-1 iteration: next u/v/r/s from current values and the u>v comparator result.
module kaliski_step_datapath #(
    parameter int unsigned W = 256
) (
    input  logic [W-1:0] u_i,
    input  logic [W-1:0] v_i,
    input  logic [W:0]   r_i,
    input  logic [W:0]   s_i,
    input  logic         u_gt_v_i,
    output logic [W-1:0] u_o,
    output logic [W-1:0] v_o,
    output logic [W:0]   r_o,
    output logic [W:0]   s_o
);

    logic [W-1:0] u_minus_v;
    logic [W-1:0] v_minus_u;

    always_comb begin
        u_minus_v = u_i - v_i;
        v_minus_u = v_i - u_i;
        u_o = u_i;
        v_o = v_i;
        r_o = r_i;
        s_o = s_i;
        if (!u_i[0]) begin
            u_o = u_i >> 1;
            s_o = s_i << 1;
        end else if (!v_i[0]) begin
            v_o = v_i >> 1;
            r_o = r_i << 1;
        end else if (u_gt_v_i) begin
            u_o = u_minus_v >> 1;
            r_o = r_i + s_i;
            s_o = s_i << 1;
        end else begin
            v_o = v_minus_u >> 1;
            s_o = s_i + r_i;
            r_o = r_i << 1;
        end
    end

endmodule

// File: rtl/kaliski_phase1_engine.sv
// Kaliski phase-1 almost-Montgomery-inverse engine: x = a^-1 * 2^k mod p with iteration count k.
// Optional gcd(a,p)!=1 error detection is enabled by defining KALISKI_GCD_CHECK_EN.
module kaliski_phase1_engine #(
    parameter int unsigned W  = kaliski_pkg::W_DEF,
    parameter int unsigned KW = kaliski_pkg::KW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    input  logic [W-1:0]  p_in,
    input  logic [W-1:0]  a_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  x_out,
    output logic [KW-1:0] k_out,
    output logic          err_out
);
    import kaliski_pkg::*;

    localparam int unsigned WR = W + 1;

    typedef struct packed {
        logic [W-1:0]  x;
        logic [KW-1:0] k;
        logic          err;
    } res_t;

    state_e        state_q, state_d;
    logic [W-1:0]  u_q, u_d, v_q, v_d, p_q, p_d;
    logic [W:0]    r_q, r_d, s_q, s_d;
    logic [KW-1:0] k_q, k_d;
    res_t          res_q, res_d;
    logic          out_valid_q, out_valid_d;

    logic [W-1:0]  u_nx, v_nx;
    logic [W:0]    r_nx, s_nx;
    logic          u_gt_v;
    logic          r_ge_p;
    logic [W-1:0]  x_calc;
    logic          err_calc;

    assign u_gt_v = (u_q > v_q);
    assign r_ge_p = (r_q >= {1'b0, p_q});

    // r < 2p, so after one conditional subtract r' < p and its bit W is always zero.
    assign x_calc = p_q - (r_ge_p ? (r_q[W-1:0] - p_q) : r_q[W-1:0]);

`ifdef KALISKI_GCD_CHECK_EN
    assign err_calc = (k_q == '0) || (u_q != W'(1));
`else
    assign err_calc = (k_q == '0);
`endif

    kaliski_step_datapath #(
        .W (W)
    ) u_step (
        .u_i      (u_q),
        .v_i      (v_q),
        .r_i      (r_q),
        .s_i      (s_q),
        .u_gt_v_i (u_gt_v),
        .u_o      (u_nx),
        .v_o      (v_nx),
        .r_o      (r_nx),
        .s_o      (s_nx)
    );

    always_comb begin
        state_d     = state_q;
        u_d         = u_q;
        v_d         = v_q;
        r_d         = r_q;
        s_d         = s_q;
        p_d         = p_q;
        k_d         = k_q;
        res_d       = res_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ITER;
                    u_d     = p_in;
                    v_d     = a_in;
                    p_d     = p_in;
                    r_d     = '0;
                    s_d     = WR'(1);
                    k_d     = '0;
                end
            end
            ITER: begin
                if (v_q == '0) begin
                    state_d = REDUCE;
                end else begin
                    u_d = u_nx;
                    v_d = v_nx;
                    r_d = r_nx;
                    s_d = s_nx;
                    k_d = k_q + KW'(1);
                end
            end
            REDUCE: begin
                res_d.err = err_calc;
                res_d.x   = err_calc ? '0 : x_calc;
                res_d.k   = k_q;
                state_d   = DONE;
            end
            DONE: begin
                // valid is registered one cycle into DONE; the handshake only counts once it is visible
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            u_q         <= '0;
            v_q         <= '0;
            r_q         <= '0;
            s_q         <= '0;
            p_q         <= '0;
            k_q         <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            u_q         <= u_d;
            v_q         <= v_d;
            r_q         <= r_d;
            s_q         <= s_d;
            p_q         <= p_d;
            k_q         <= k_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign x_out     = res_q.x;
    assign k_out     = res_q.k;
    assign err_out   = res_q.err;

endmodule

// File: tb/tb_kaliski_phase1_engine.sv
// Self-checking bench for kaliski_phase1_engine: W=8 directed/scoreboard cases plus W=256 random cases.
module tb_kaliski_phase1_engine;

    logic       clk;
    logic       rst;
    logic       start, ready, out_valid, out_ready, err_out;
    logic [7:0] p_in, a_in, x_out;
    logic [4:0] k_out;

    logic         startw, readyw, out_validw, out_readyw, err_outw;
    logic [255:0] p_inw, a_inw, x_outw;
    logic [9:0]   k_outw;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] x;
        logic [4:0] k;
        logic       err;
        int         lat;
    } exp_t;
    exp_t sb8[$];

    typedef struct {
        logic [255:0] p;
        logic [255:0] a;
    } wreq_t;
    wreq_t sbw[$];

`ifdef KALISKI_GCD_CHECK_EN
    localparam logic [7:0] NC_X = 8'd0;
    localparam logic       NC_E = 1'b1;
`else
    localparam logic [7:0] NC_X = 8'd13;
    localparam logic       NC_E = 1'b0;
`endif

    kaliski_phase1_engine #(
        .W  (8),
        .KW (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .p_in      (p_in),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .k_out     (k_out),
        .err_out   (err_out)
    );

    kaliski_phase1_engine #(
        .W  (256),
        .KW (10)
    ) dutw (
        .clk       (clk),
        .rst       (rst),
        .start     (startw),
        .ready     (readyw),
        .p_in      (p_inw),
        .a_in      (a_inw),
        .out_valid (out_validw),
        .out_ready (out_readyw),
        .x_out     (x_outw),
        .k_out     (k_outw),
        .err_out   (err_outw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue8(input logic [7:0] p, input logic [7:0] a);
        int guard = 0;
        while (!ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        p_in = p; a_in = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic ack8();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic txn8(input logic [7:0] p, input logic [7:0] a,
                        output logic [7:0] x, output logic [4:0] k, output logic e, output int lat);
        issue8(p, a);
        wait8(lat);
        x = x_out; k = k_out; e = err_out;
        ack8();
    endtask

    task automatic check8(input string name, input logic [7:0] x, input logic [4:0] k,
                          input logic e, input int lat);
        exp_t ex;
        if (sb8.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_sb: scoreboard empty", name);
        end else begin
            ex = sb8.pop_front();
            total++;
            if (x !== ex.x) begin bad++; $display("FAIL %s_x: got %0d want %0d", name, x, ex.x); end
            total++;
            if (k !== ex.k) begin bad++; $display("FAIL %s_k: got %0d want %0d", name, k, ex.k); end
            total++;
            if (e !== ex.err) begin bad++; $display("FAIL %s_err: got %0b want %0b", name, e, ex.err); end
            if (ex.lat >= 0) begin
                total++;
                if (lat != ex.lat) begin bad++; $display("FAIL %s_lat: got %0d want %0d", name, lat, ex.lat); end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        total++; if (x_out !== 8'd0) begin bad++; $display("FAIL reset_x: got %0d want 0", x_out); end
        total++; if (k_out !== 5'd0) begin bad++; $display("FAIL reset_k: got %0d want 0", k_out); end
        total++; if (err_out !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err_out); end
        total++; if (readyw !== 1'b1) begin bad++; $display("FAIL reset_readyw: got %0b want 1", readyw); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] x; logic [4:0] k; logic e; int lat;
        sb8.push_back('{x: 8'd1, k: 5'd4, err: 1'b0, lat: 7});
        txn8(8'd13, 8'd3, x, k, e, lat);
        check8("basic", x, k, e, lat);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop: valid got %0b want 0", out_valid); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_idle: ready got %0b want 1", ready); end
    endtask

    task automatic test_zero();
        logic [7:0] x; logic [4:0] k; logic e; int lat;
        sb8.push_back('{x: 8'd0, k: 5'd0, err: 1'b1, lat: 3});
        txn8(8'd13, 8'd0, x, k, e, lat);
        check8("zero", x, k, e, lat);
    endtask

    task automatic test_noncoprime();
        logic [7:0] x; logic [4:0] k; logic e; int lat;
        sb8.push_back('{x: NC_X, k: 5'd4, err: NC_E, lat: 7});
        txn8(8'd15, 8'd6, x, k, e, lat);
        check8("noncoprime", x, k, e, lat);
    endtask

    task automatic test_math8();
        int ps[4] = '{251, 255, 129, 3};
        int as[4] = '{7, 254, 128, 2};
        logic [7:0] x; logic [4:0] k; logic e; int lat;
        for (int i = 0; i < 4; i++) begin
            int lhs, rhs;
            txn8(8'(ps[i]), 8'(as[i]), x, k, e, lat);
            lhs = (int'(x) * as[i]) % ps[i];
            rhs = 1;
            for (int j = 0; j < int'(k); j++) rhs = (rhs * 2) % ps[i];
            total++;
            if (lhs != rhs) begin bad++; $display("FAIL math8_%0d_inv: x*a mod p got %0d want %0d", i, lhs, rhs); end
            total++;
            if (e !== 1'b0) begin bad++; $display("FAIL math8_%0d_err: got %0b want 0", i, e); end
            total++;
            if (k > 5'd16 || (ps[i] >= 128 && k < 5'd8)) begin
                bad++; $display("FAIL math8_%0d_krange: got %0d want 8..16", i, k);
            end
            total++;
            if (lat != int'(k) + 3) begin bad++; $display("FAIL math8_%0d_lat: got %0d want %0d", i, lat, int'(k) + 3); end
        end
    endtask

    task automatic test_busy_hold();
        int lat;
        sb8.push_back('{x: 8'd1, k: 5'd4, err: 1'b0, lat: 5});
        issue8(8'd13, 8'd3);
        start = 1'b1; p_in = 8'd15; a_in = 8'd6; out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %0b want 0", ready); end
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b0;
        wait8(lat);
        check8("busy", x_out, k_out, err_out, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || x_out !== 8'd1 || k_out !== 5'd4 || err_out !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: valid=%0b x=%0d k=%0d err=%0b want valid=1 x=1 k=4 err=0",
                         i, out_valid, x_out, k_out, err_out);
            end
        end
        ack8();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_drop: valid got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] x; logic [4:0] k; logic e; int lat;
        int seen = 0;
        issue8(8'd13, 8'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %0b want 1", ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
        total++; if (x_out !== 8'd0) begin bad++; $display("FAIL rstmid_x: got %0d want 0", x_out); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid_pulse: valid cycles got %0d want 0", seen); end
        sb8.push_back('{x: 8'd1, k: 5'd4, err: 1'b0, lat: 7});
        txn8(8'd13, 8'd3, x, k, e, lat);
        check8("rstmid", x, k, e, lat);
    endtask

    task automatic test_back_to_back();
        logic [7:0] tp[3] = '{8'd13, 8'd13, 8'd15};
        logic [7:0] ta[3] = '{8'd3, 8'd0, 8'd6};
        logic [7:0] x; logic [4:0] k; logic e; int lat;
        sb8.push_back('{x: 8'd1, k: 5'd4, err: 1'b0, lat: 7});
        sb8.push_back('{x: 8'd0, k: 5'd0, err: 1'b1, lat: 3});
        sb8.push_back('{x: NC_X, k: 5'd4, err: NC_E, lat: 7});
        for (int i = 0; i < 3; i++) begin
            txn8(tp[i], ta[i], x, k, e, lat);
            check8("b2b", x, k, e, lat);
        end
    endtask

    function automatic logic [255:0] gcd256(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] t;
        while (b != '0) begin
            t = a % b; a = b; b = t;
        end
        return a;
    endfunction

    function automatic logic [255:0] pow2mod(input int k, input logic [255:0] p);
        logic [256:0] acc = 257'd1;
        for (int i = 0; i < k; i++) begin
            acc = acc << 1;
            if (acc >= {1'b0, p}) acc = acc - {1'b0, p};
        end
        return acc[255:0];
    endfunction

    task automatic test_wide();
        for (int n = 0; n < 4; n++) begin
            wreq_t rq;
            logic [511:0] prod;
            logic [255:0] lhs, rhs;
            int lat = 0;
            int guard = 0;
            for (int i = 0; i < 8; i++) rq.p[i*32 +: 32] = $urandom;
            rq.p[255] = 1'b1; rq.p[0] = 1'b1;
            do begin
                for (int i = 0; i < 8; i++) rq.a[i*32 +: 32] = $urandom;
                rq.a = rq.a % rq.p;
                guard++;
            end while ((rq.a == '0 || gcd256(rq.p, rq.a) != 256'd1) && guard < 50);
            sbw.push_back(rq);
            p_inw = rq.p; a_inw = rq.a; startw = 1'b1;
            @(posedge clk); #1;
            startw = 1'b0;
            while (!out_validw && lat < 2000) begin
                @(posedge clk); #1; lat++;
            end
            rq = sbw.pop_front();
            prod = {256'd0, x_outw} * {256'd0, rq.a};
            prod = prod % {256'd0, rq.p};
            lhs = prod[255:0];
            rhs = pow2mod(int'(k_outw), rq.p);
            total++;
            if (lhs !== rhs) begin bad++; $display("FAIL wide_%0d_inv: x*a mod p got %0h want %0h", n, lhs, rhs); end
            total++;
            if (k_outw < 10'd256 || k_outw > 10'd512) begin
                bad++; $display("FAIL wide_%0d_krange: got %0d want 256..512", n, k_outw);
            end
            total++;
            if (err_outw !== 1'b0) begin bad++; $display("FAIL wide_%0d_err: got %0b want 0", n, err_outw); end
            total++;
            if (lat != int'(k_outw) + 3) begin
                bad++; $display("FAIL wide_%0d_lat: got %0d want %0d", n, lat, int'(k_outw) + 3);
            end
            out_readyw = 1'b1;
            @(posedge clk); #1;
            out_readyw = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; p_in = '0; a_in = '0;
        startw = 1'b0; out_readyw = 1'b0; p_inw = '0; a_inw = '0;
        test_reset();
        test_basic();
        test_zero();
        test_noncoprime();
        test_math8();
        test_busy_hold();
        test_reset_mid();
        test_back_to_back();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
